// File: rtl/merge_pipe_reg_pkg.sv
// Shared widths, stats FSM encoding and helpers for the post-merge pipeline register.
// Widths mirror the router-wide settings; STAT_CNT_W is the default statistics counter width.
package merge_pipe_reg_pkg;

    localparam int NUM_PORT       = 5;
    localparam int SRC_LIST_WIDTH = 8;
    localparam int MEM_ADDR_WIDTH = 8;
    localparam int DST_WIDTH      = 4;
    localparam int NUM_FLIT_WDITH = 3;
    localparam int STAT_CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SNAP = 2'd1,
        ST_ACK  = 2'd2,
        ST_WAIT = 2'd3
    } stat_state_t;

    function automatic logic [2:0] kill_popcount(input logic [NUM_PORT-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/merge_pipe_reg_sat_cnt.sv
// Saturating up-counter with an increment of 0..7 and a clear that preloads
// the current cycle's increment so events coinciding with a clear are kept.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   inc,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W:0] MAX = {1'b0, {W{1'b1}}};

    logic [W-1:0] inc_eff;
    logic [W:0]   sum;

    always_comb begin
        inc_eff = en ? W'(inc) : '0;
        sum     = {1'b0, count} + {1'b0, inc_eff};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= inc_eff;
        end else if (sum > MAX) begin
            count <= '1;
        end else begin
            count <= sum[W-1:0];
        end
    end

endmodule

// File: rtl/merge_pipe_reg.sv
// Pipeline register after the merge stage: registers the per-port flits, drops
// valid on killed ports, and keeps kill statistics behind a req/ack snapshot.
module merge_pipe_reg
    import merge_pipe_reg_pkg::*;
#(
    parameter int PAYLOAD_W   = 64,
    parameter int CNT_W       = STAT_CNT_W,
    parameter int CLR_ON_SNAP = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                stall,
    input  logic [NUM_PORT-1:0]                 hs_in,
    input  logic [NUM_PORT-1:0]                 kill_in,
    input  logic [NUM_PORT*SRC_LIST_WIDTH-1:0]  srcList_in,
    input  logic [NUM_PORT*MEM_ADDR_WIDTH-1:0]  addr_in,
    input  logic [NUM_PORT*DST_WIDTH-1:0]       dst_in,
    input  logic [NUM_PORT*NUM_FLIT_WDITH-1:0]  flitID_in,
    input  logic [NUM_PORT*PAYLOAD_W-1:0]       payload_in,
    output logic [NUM_PORT-1:0]                 hs_out,
    output logic [NUM_PORT*SRC_LIST_WIDTH-1:0]  srcList_out,
    output logic [NUM_PORT*MEM_ADDR_WIDTH-1:0]  addr_out,
    output logic [NUM_PORT*DST_WIDTH-1:0]       dst_out,
    output logic [NUM_PORT*NUM_FLIT_WDITH-1:0]  flitID_out,
    output logic [NUM_PORT*PAYLOAD_W-1:0]       payload_out,
    input  logic                                stat_req,
    output logic                                stat_ack,
    output logic [NUM_PORT*CNT_W-1:0]           stat_kill_cnt,
    output logic [CNT_W-1:0]                    stat_merge_tot
);

    stat_state_t                state, state_nxt;
    logic                       snap_take;
    logic                       snap_clr;
    logic                       cnt_en;
    logic [NUM_PORT-1:0]        kill_hit;
    logic [NUM_PORT*CNT_W-1:0]  kill_cnt;
    logic [CNT_W-1:0]           merge_tot;

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_out      <= '0;
            srcList_out <= '0;
            addr_out    <= '0;
            dst_out     <= '0;
            flitID_out  <= '0;
            payload_out <= '0;
        end else if (!stall) begin
            hs_out      <= hs_in & ~kill_in;
            srcList_out <= srcList_in;
            addr_out    <= addr_in;
            dst_out     <= dst_in;
            flitID_out  <= flitID_in;
            payload_out <= payload_in;
        end
    end

    // A kill on an already-invalid port clears nothing real, so it is not counted.
    assign cnt_en   = !stall;
    assign kill_hit = cnt_en ? (kill_in & hs_in) : '0;
    assign snap_clr = snap_take && (CLR_ON_SNAP != 0);

    for (genvar p = 0; p < NUM_PORT; p++) begin : g_kill_cnt
        sat_cnt #(.W(CNT_W)) u_kill_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   ({2'b00, kill_hit[p]}),
            .clr   (snap_clr),
            .en    (cnt_en),
            .count (kill_cnt[p*CNT_W +: CNT_W])
        );
    end

    sat_cnt #(.W(CNT_W)) u_merge_tot (
        .clk   (clk),
        .reset (reset),
        .inc   (kill_popcount(kill_hit)),
        .clr   (snap_clr),
        .en    (cnt_en),
        .count (merge_tot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        snap_take = 1'b0;
        stat_ack  = 1'b0;
        unique case (state)
            ST_IDLE: if (stat_req) state_nxt = ST_SNAP;
            ST_SNAP: begin
                snap_take = 1'b1;
                state_nxt = ST_ACK;
            end
            ST_ACK: begin
                stat_ack  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: if (!stat_req) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_kill_cnt  <= '0;
            stat_merge_tot <= '0;
        end else if (snap_take) begin
            stat_kill_cnt  <= kill_cnt;
            stat_merge_tot <= merge_tot;
        end
    end

endmodule

// File: tb/tb_merge_pipe_reg.sv
// Self-checking bench for merge_pipe_reg: datapath scoreboard plus a stats model.
module tb_merge_pipe_reg;
    import merge_pipe_reg_pkg::*;

    localparam int NP = NUM_PORT;
    localparam int PW = 64;
    localparam int CW = 4;
    localparam int SW = SRC_LIST_WIDTH;
    localparam int AW = MEM_ADDR_WIDTH;
    localparam int DW = DST_WIDTH;
    localparam int FW = NUM_FLIT_WDITH;
    localparam int unsigned MAXC = (1 << CW) - 1;

    logic                clk = 1'b0;
    logic                reset, stall, stat_req, stat_ack;
    logic [NP-1:0]       hs_in, kill_in, hs_out;
    logic [NP*SW-1:0]    srcList_in, srcList_out;
    logic [NP*AW-1:0]    addr_in, addr_out;
    logic [NP*DW-1:0]    dst_in, dst_out;
    logic [NP*FW-1:0]    flitID_in, flitID_out;
    logic [NP*PW-1:0]    payload_in, payload_out;
    logic [NP*CW-1:0]    stat_kill_cnt;
    logic [CW-1:0]       stat_merge_tot;

    merge_pipe_reg #(.PAYLOAD_W(PW), .CNT_W(CW), .CLR_ON_SNAP(1)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .hs_in(hs_in), .kill_in(kill_in), .srcList_in(srcList_in), .addr_in(addr_in),
        .dst_in(dst_in), .flitID_in(flitID_in), .payload_in(payload_in),
        .hs_out(hs_out), .srcList_out(srcList_out), .addr_out(addr_out), .dst_out(dst_out),
        .flitID_out(flitID_out), .payload_out(payload_out),
        .stat_req(stat_req), .stat_ack(stat_ack),
        .stat_kill_cnt(stat_kill_cnt), .stat_merge_tot(stat_merge_tot)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NP-1:0]    hs;
        logic [NP*SW-1:0] src;
        logic [NP*AW-1:0] addr;
        logic [NP*DW-1:0] dst;
        logic [NP*FW-1:0] fid;
        logic [NP*PW-1:0] pay;
    } dp_t;

    dp_t         dp_q[$];
    dp_t         dp_hold;
    int unsigned m_cnt[NP];
    int unsigned m_tot;
    int unsigned m_snap[NP];
    int unsigned m_snap_tot;
    int          m_st;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b);
        return (a + b > MAXC) ? MAXC : a + b;
    endfunction

    task automatic randomize_fields();
        srcList_in = SW*NP'($urandom) ^ {$urandom, 8'h00};
        addr_in    = {$urandom, $urandom};
        dst_in     = 20'($urandom);
        flitID_in  = 15'($urandom);
        for (int i = 0; i < NP*PW/32; i++) payload_in[i*32 +: 32] = $urandom;
    endtask

    // Build the expected result for the current inputs, clock once, then compare.
    task automatic tick();
        dp_t         e;
        int unsigned inc, k;
        if (reset) begin
            e = '0;
            for (int p = 0; p < NP; p++) begin m_cnt[p] = 0; m_snap[p] = 0; end
            m_tot = 0; m_snap_tot = 0; m_st = 0;
        end else begin
            if (stall) e = dp_hold;
            else e = '{hs: hs_in & ~kill_in, src: srcList_in, addr: addr_in,
                       dst: dst_in, fid: flitID_in, pay: payload_in};
            k = 0;
            for (int p = 0; p < NP; p++) begin
                inc = (!stall && kill_in[p] && hs_in[p]) ? 1 : 0;
                k += inc;
                if (m_st == 1) begin m_snap[p] = m_cnt[p]; m_cnt[p] = inc; end
                else m_cnt[p] = sat_add(m_cnt[p], inc);
            end
            if (m_st == 1) begin m_snap_tot = m_tot; m_tot = k; end
            else m_tot = sat_add(m_tot, k);
            case (m_st)
                0: if (stat_req) m_st = 1;
                1: m_st = 2;
                2: m_st = 3;
                default: if (!stat_req) m_st = 0;
            endcase
        end
        dp_hold = e;
        dp_q.push_back(e);
        @(posedge clk);
        #1;
        e = dp_q.pop_front();
        chk("hs_out", hs_out, e.hs);
        chk("srcList_out", srcList_out, e.src);
        chk("addr_out", addr_out, e.addr);
        chk("dst_out", dst_out, e.dst);
        chk("flitID_out", flitID_out, e.fid);
        chk("payload_out", payload_out, e.pay);
        chk("stat_ack", stat_ack, (m_st == 2));
        if (m_st == 2) begin
            for (int p = 0; p < NP; p++) chk("snap_kill_cnt", stat_kill_cnt[p*CW +: CW], m_snap[p]);
            chk("snap_merge_tot", stat_merge_tot, m_snap_tot);
        end
    endtask

    task automatic do_snap();
        logic got;
        got = 1'b0;
        stat_req = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (stat_ack) got = 1'b1;
        end
        chk("snap_ack_seen", got, 1'b1);
        stat_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int ack_cnt, ack_at;
        reset = 1'b1; stall = 1'b0; stat_req = 1'b0;
        hs_in = 5'b11111; kill_in = '0;
        randomize_fields();
        dp_hold = '0;

        // 1: reset
        tick(); tick();
        chk("t1_hs_out", hs_out, 5'b00000);
        chk("t1_ack", stat_ack, 1'b0);
        chk("t1_snap_cnt", stat_kill_cnt, '0);
        chk("t1_snap_tot", stat_merge_tot, '0);
        reset = 1'b0;

        // 2: basic kill
        kill_in = 5'b01010;
        srcList_in[SW-1:0] = 8'h03;
        tick();
        chk("t2_hs_out", hs_out, 5'b10101);
        chk("t2_src0", srcList_out[SW-1:0], 8'h03);

        // 3: stall holds everything and ignores kills
        stall = 1'b1; kill_in = 5'b11110;
        randomize_fields();
        for (int i = 0; i < 3; i++) tick();
        chk("t3_hs_hold", hs_out, 5'b10101);
        stall = 1'b0; kill_in = '0;
        do_snap();
        chk("t3_cnt1", stat_kill_cnt[1*CW +: CW], 1);
        chk("t3_cnt3", stat_kill_cnt[3*CW +: CW], 1);
        chk("t3_cnt4", stat_kill_cnt[4*CW +: CW], 0);
        chk("t3_tot", stat_merge_tot, 2);

        // random legal traffic
        for (int i = 0; i < 40; i++) begin
            hs_in   = 5'($urandom);
            kill_in = 5'($urandom) & hs_in & 5'b11110;
            stall   = ($urandom_range(0, 3) == 0);
            randomize_fields();
            tick();
        end
        stall = 1'b0; kill_in = '0;
        do_snap();

        // 4: saturation
        hs_in = 5'b11111; kill_in = 5'b10000;
        for (int i = 0; i < 20; i++) tick();
        kill_in = '0;
        do_snap();
        chk("t4_cnt4_sat", stat_kill_cnt[4*CW +: CW], 15);
        chk("t4_tot_sat", stat_merge_tot, 15);

        // 5: clear-on-snapshot with concurrent kills
        kill_in = 5'b00100; stat_req = 1'b1;
        ack_cnt = 0; ack_at = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (stat_ack) begin
                ack_cnt++;
                if (ack_at == 0) ack_at = i + 1;
                chk("t5_snap_cnt2", stat_kill_cnt[2*CW +: CW], 1);
                chk("t5_snap_tot", stat_merge_tot, 1);
            end
        end
        chk("t5_ack_count", ack_cnt, 1);
        chk("t5_ack_latency", ack_at, 2);
        stat_req = 1'b0; kill_in = '0;
        tick(); tick();
        do_snap();
        chk("t5_live_cnt2", stat_kill_cnt[2*CW +: CW], 4);
        chk("t5_live_tot", stat_merge_tot, 4);

        // 6: reset during SNAP
        kill_in = 5'b01000;
        for (int i = 0; i < 6; i++) tick();
        kill_in = '0; stat_req = 1'b1;
        tick();
        reset = 1'b1; stat_req = 1'b0;
        tick();
        reset = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (stat_ack) ack_cnt++;
        end
        chk("t6_no_ack", ack_cnt, 0);
        do_snap();
        chk("t6_snap_cnt", stat_kill_cnt, '0);
        chk("t6_snap_tot", stat_merge_tot, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
